// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: I2C target with 7-bit address match and pointer-based register bank access.
// Optional I2C_SLV_GLITCH_FILT_EN adds a 3-tap majority filter on SCL/SDA after the synchronizer.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         AW         = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    output logic          reg_we,
    input  logic [7:0]    reg_rdata,
    output logic          busy
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, PTR, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK} state_t;

    state_t        state, state_n;
    logic [1:0]    scl_sync, sda_sync;
    logic          scl_q, sda_q, scl_p, sda_p;
    logic          scl_rise, scl_fall, start, stop;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shifter, shifter_n, byte_in;
    logic          rw, rw_n, ph, ph_n, data_ack, data_ack_n;
    logic          sda_oe_n, reg_we_n, busy_n;
    logic [AW-1:0] reg_addr_n, ptr_inc;
    logic [7:0]    reg_wdata_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_p    <= scl_q;
            sda_p    <= sda_q;
        end
    end

`ifdef I2C_SLV_GLITCH_FILT_EN
    logic [2:0] scl_t, sda_t;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_t <= 3'b111;
            sda_t <= 3'b111;
        end else begin
            scl_t <= {scl_t[1:0], scl_sync[1]};
            sda_t <= {sda_t[1:0], sda_sync[1]};
        end
    end

    // a single-clk pulse only ever occupies one tap, so the vote never flips
    assign scl_q = (scl_t[0] & scl_t[1]) | (scl_t[0] & scl_t[2]) | (scl_t[1] & scl_t[2]);
    assign sda_q = (sda_t[0] & sda_t[1]) | (sda_t[0] & sda_t[2]) | (sda_t[1] & sda_t[2]);
`else
    assign scl_q = scl_sync[1];
    assign sda_q = sda_sync[1];
`endif

    assign scl_rise = scl_q & ~scl_p;
    assign scl_fall = ~scl_q & scl_p;
    assign start    = scl_q & scl_p & sda_p & ~sda_q;
    assign stop     = scl_q & scl_p & ~sda_p & sda_q;
    assign byte_in  = {shifter[6:0], sda_q};
    assign ptr_inc  = reg_addr + AW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shifter   <= 8'h00;
            rw        <= 1'b0;
            ph        <= 1'b0;
            data_ack  <= 1'b0;
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shifter   <= shifter_n;
            rw        <= rw_n;
            ph        <= ph_n;
            data_ack  <= data_ack_n;
            sda_oe    <= sda_oe_n;
            reg_addr  <= reg_addr_n;
            reg_wdata <= reg_wdata_n;
            reg_we    <= reg_we_n;
            busy      <= busy_n;
        end
    end

    // ph: in ACK states, 0 = waiting to drive ACK, 1 = ACK on the bus;
    // in RD_BYTE, 1 = reload from reg_rdata on the next scl_fall;
    // in RD_ACK, 0 = still driving bit 0, 1 = released and awaiting master bit.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shifter_n   = shifter;
        rw_n        = rw;
        ph_n        = ph;
        data_ack_n  = data_ack;
        sda_oe_n    = sda_oe;
        reg_addr_n  = reg_addr;
        reg_wdata_n = reg_wdata;
        reg_we_n    = 1'b0;
        busy_n      = busy;
        if (stop) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
            ph_n     = 1'b0;
        end else if (start) begin
            state_n   = ADDR;
            sda_oe_n  = 1'b0;
            bit_cnt_n = 3'd0;
            ph_n      = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WR_BYTE: begin
                    if (scl_rise) begin
                        shifter_n = byte_in;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ph_n = 1'b0;
                            if (state == ADDR) begin
                                if (byte_in[7:1] == SLAVE_ADDR) begin
                                    state_n = ADDR_ACK;
                                    rw_n    = byte_in[0];
                                    busy_n  = 1'b1;
                                end else begin
                                    state_n = IDLE;
                                    busy_n  = 1'b0;
                                end
                            end else begin
                                state_n    = WR_ACK;
                                data_ack_n = (state == WR_BYTE);
                                if (state == PTR) begin
                                    reg_addr_n = AW'(byte_in);
                                end else begin
                                    reg_wdata_n = byte_in;
                                    reg_we_n    = 1'b1;
                                end
                            end
                        end
                    end
                end
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n = ~ph;
                        ph_n     = ~ph;
                        if (ph) begin
                            bit_cnt_n = 3'd0;
                            if (state == WR_ACK) begin
                                state_n    = WR_BYTE;
                                reg_addr_n = data_ack ? ptr_inc : reg_addr;
                            end else if (rw) begin
                                state_n   = RD_BYTE;
                                shifter_n = reg_rdata;
                                sda_oe_n  = ~reg_rdata[7];
                            end else begin
                                state_n = PTR;
                            end
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_fall) begin
                        shifter_n = ph ? reg_rdata : {shifter[6:0], 1'b0};
                        sda_oe_n  = ph ? ~reg_rdata[7] : ~shifter[6];
                        ph_n      = 1'b0;
                    end
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        state_n   = (bit_cnt == 3'd7) ? RD_ACK : RD_BYTE;
                    end
                end
                RD_ACK: begin
                    if (scl_fall && !ph) begin
                        sda_oe_n = 1'b0;
                        ph_n     = 1'b1;
                    end else if (scl_rise && ph) begin
                        // pointer advances past every byte read; reload only if the master ACKed
                        reg_addr_n = ptr_inc;
                        bit_cnt_n  = 3'd0;
                        state_n    = sda_q ? IDLE : RD_BYTE;
                        busy_n     = ~sda_q;
                        ph_n       = ~sda_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder: bit-banged I2C master with randomized transactions checked
// against a register-bank model that tracks pointer and expected writes.
module tb_i2c_slave_responder;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda;
    logic       sda_oe, reg_we, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;

    logic [7:0]  mem [256] = '{default: 8'h00};
    logic [7:0]  exp_mem [256] = '{default: 8'h00};
    logic [15:0] wq [$];
    logic [15:0] ew [$];
    logic [7:0]  dbuf [4];
    int          oe_cnt = 0;
    int          wi = 0;
    int          exp_ptr = 0;
    int          errors = 0;
    int          checks = 0;

    i2c_slave_responder dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda), .sda_oe(sda_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .reg_rdata(reg_rdata), .busy(busy)
    );

    assign sda       = sda_m & ~sda_oe;
    assign reg_rdata = mem[reg_addr];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_we) begin
            mem[reg_addr] <= reg_wdata;
            wq.push_back({reg_addr, reg_wdata});
        end
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, input logic g, output logic r);
        sda_m = b;
        wt(Q);
        scl = 1'b1;
        wt(Q);
        if (g) begin
            sda_m = 1'b0;
            wt(1);
            sda_m = b;
            wt(1);
        end
        r = sda;
        wt(Q);
        scl = 1'b0;
        wt(Q);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1;
        wt(Q);
        scl = 1'b1;
        wt(Q);
        sda_m = 1'b0;
        wt(Q);
        scl = 1'b0;
        wt(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0;
        wt(Q);
        scl = 1'b1;
        wt(Q);
        sda_m = 1'b1;
        wt(Q);
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], 1'b0, r);
        clk_bit(1'b1, 1'b0, ack);
    endtask

    task automatic rbyte(output logic [7:0] b, input logic mack);
        logic r;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, 1'b0, r);
            b = {b[6:0], r};
        end
        clk_bit(mack, 1'b0, r);
    endtask

    task automatic flush_writes(input string tag);
        check({tag, "_we_count"}, wq.size() - wi, ew.size());
        for (int i = 0; i < ew.size() && wi + i < wq.size(); i++)
            check({tag, "_we_entry"}, wq[wi+i], ew[i]);
        wi = wq.size();
        ew.delete();
    endtask

    // model: a matched write sets the pointer, then each data byte lands at the pointer and bumps it
    task automatic do_write(input string tag, input logic [7:0] ab, input logic [7:0] ptr, input int n);
        logic a;
        logic hit;
        int   oe0;
        oe0 = oe_cnt;
        hit = (ab[7:1] == 7'h50) && !ab[0];
        i2c_start();
        wbyte(ab, a);
        check({tag, "_addr_ack"}, a, hit ? 1'b0 : 1'b1);
        wbyte(ptr, a);
        check({tag, "_ptr_ack"}, a, hit ? 1'b0 : 1'b1);
        if (hit) begin
            check({tag, "_busy"}, busy, 1'b1);
            exp_ptr = ptr;
        end
        for (int i = 0; i < n; i++) begin
            wbyte(dbuf[i], a);
            check({tag, "_data_ack"}, a, hit ? 1'b0 : 1'b1);
            if (hit) begin
                ew.push_back({exp_ptr[7:0], dbuf[i]});
                exp_mem[exp_ptr] = dbuf[i];
                exp_ptr = (exp_ptr + 1) % 256;
            end
        end
        i2c_stop();
        wt(4);
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_ptr_end"}, reg_addr, exp_ptr);
        if (!hit) check({tag, "_miss_oe"}, oe_cnt - oe0, 0);
        flush_writes(tag);
    endtask

    task automatic do_read(input string tag, input logic [7:0] ptr, input int n);
        logic       a;
        logic [7:0] b;
        i2c_start();
        wbyte(8'hA0, a);
        check({tag, "_addr_ack"}, a, 1'b0);
        wbyte(ptr, a);
        check({tag, "_ptr_ack"}, a, 1'b0);
        i2c_start();
        wbyte(8'hA1, a);
        check({tag, "_rd_addr_ack"}, a, 1'b0);
        exp_ptr = ptr;
        for (int i = 0; i < n; i++) begin
            rbyte(b, i == n - 1);
            check({tag, "_rd_byte"}, b, exp_mem[exp_ptr]);
            exp_ptr = (exp_ptr + 1) % 256;
        end
        check({tag, "_busy_nack"}, busy, 1'b0);
        i2c_stop();
        wt(4);
        check({tag, "_ptr_end"}, reg_addr, exp_ptr);
        flush_writes(tag);
    endtask

    initial begin
        logic       a, r;
        logic [6:0] ma;
        int         n;
        wt(3);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_reg_addr", reg_addr, 8'h00);
        check("rst_reg_we", reg_we, 1'b0);
        check("rst_reg_wdata", reg_wdata, 8'h00);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        wt(4);

        dbuf[0] = 8'h5A;
        do_write("wr_basic", 8'hA0, 8'h03, 1);
        check("wr_basic_wdata", reg_wdata, 8'h5A);

        dbuf[0] = 8'h3C;
        dbuf[1] = 8'hC3;
        do_write("rd_setup", 8'hA0, 8'h07, 2);
        do_read("rd_random", 8'h07, 2);
        check("rd_ptr9", reg_addr, 8'h09);

        do_write("miss_a2", 8'hA2, 8'h11, 1);
        do_write("miss_gc", 8'h00, 8'h11, 1);

        dbuf[0] = 8'h01;
        dbuf[1] = 8'h02;
        do_write("wrap", 8'hA0, 8'hFF, 2);
        check("wrap_ptr", reg_addr, 8'h01);

        i2c_start();
        wbyte(8'hA0, a);
        wbyte(8'h20, a);
        for (int i = 0; i < 4; i++) clk_bit(i[0], 1'b0, r);
        i2c_stop();
        wt(4);
        exp_ptr = 8'h20;
        check("abort_busy", busy, 1'b0);
        check("abort_ptr", reg_addr, exp_ptr);
        flush_writes("abort");

        i2c_start();
        wbyte(8'hA0, a);
        wbyte(8'h30, a);
        exp_ptr = 8'h30;
        for (int i = 7; i >= 0; i--) clk_bit(1'b1, i == 5, r);
        clk_bit(1'b1, 1'b0, a);
        i2c_stop();
        wt(4);
`ifdef I2C_SLV_GLITCH_FILT_EN
        check("glitch_ack", a, 1'b0);
        ew.push_back({8'h30, 8'hFF});
        exp_mem[8'h30] = 8'hFF;
        exp_ptr = 8'h31;
`else
        check("glitch_ack", a, 1'b1);
`endif
        check("glitch_ptr", reg_addr, exp_ptr);
        flush_writes("glitch");

        for (int k = 0; k < 20; k++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom);
            case ($urandom_range(0, 2))
                0: do_write("rnd_wr", 8'hA0, 8'($urandom), n);
                1: do_read("rnd_rd", 8'($urandom), n);
                default: begin
                    ma = 7'($urandom);
                    if (ma == 7'h50) ma = 7'h51;
                    do_write("rnd_miss", {ma, 1'($urandom)}, 8'($urandom), n);
                end
            endcase
        end

        dbuf[0] = 8'h00;
        do_write("rst_setup", 8'hA0, 8'h40, 1);
        i2c_start();
        wbyte(8'hA0, a);
        wbyte(8'h40, a);
        i2c_start();
        wbyte(8'hA1, a);
        check("rst_rd_drive", sda_oe, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("rst_async_oe", sda_oe, 1'b0);
        check("rst_async_busy", busy, 1'b0);
        check("rst_async_ptr", reg_addr, 8'h00);
        scl = 1'b1;
        sda_m = 1'b1;
        wt(3);
        rst_n = 1'b1;
        wt(4);
        exp_ptr = 0;
        do_read("post_rst", 8'h40, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
